// File: rtl/codificador_pkg.sv
// Shared types and helpers for the sequential set-bit encoder.
package codificador_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int unsigned CODE_NONE = 0;

  // Code width needed to represent 0..data_w.
  function automatic int unsigned code_w(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/codificador_prioridade.sv
// Combinational lowest-set-bit encoder: code = index+1 of lowest set bit, 0 if none,
// plus a flag telling whether at most one bit of the vector is set.
module codificador_prioridade
  import codificador_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CODE_W = code_w(DATA_W)
) (
  input  logic [DATA_W-1:0] i_vec,
  output logic [CODE_W-1:0] o_code,
  output logic              o_at_most_one
);

  logic              w_found;
  logic [DATA_W-1:0] w_vec_minus_one;

  always_comb begin
    o_code  = CODE_W'(CODE_NONE);
    w_found = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i_vec[i] && !w_found) begin
        o_code  = CODE_W'(i + 1);
        w_found = 1'b1;
      end
    end
  end

  assign w_vec_minus_one = i_vec - DATA_W'(1);
  assign o_at_most_one   = ((i_vec & w_vec_minus_one) == '0);

endmodule

// File: rtl/codificador_sequencial.sv
// Sequential encoder: takes a word over valid/ready and emits one code per set bit,
// lowest bit first (or a single code 0 for an empty word) over a second valid/ready.
module codificador_sequencial
  import codificador_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                        p_Clock,
  input  logic                        p_Resetn,
  input  logic                        p_InValid,
  output logic                        p_InReady,
  input  logic [DATA_W-1:0]           p_Input,
  output logic                        p_OutValid,
  input  logic                        p_OutReady,
  output logic [code_w(DATA_W)-1:0]   p_Output,
  output logic                        p_OutLast,
  output logic                        p_Busy
);

  localparam int unsigned CODE_W = code_w(DATA_W);

  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_pend,  w_pend_next;
  logic [CODE_W-1:0] w_code;
  logic              w_one;
  logic              w_in_hs;
  logic              w_out_hs;

  codificador_prioridade #(
    .DATA_W (DATA_W),
    .CODE_W (CODE_W)
  ) u_prioridade (
    .i_vec         (r_pend),
    .o_code        (w_code),
    .o_at_most_one (w_one)
  );

  always_ff @(posedge p_Clock or negedge p_Resetn) begin
    if (!p_Resetn) begin
      r_state <= IDLE;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
    end
  end

  // Outputs derive only from state/pend; p_InReady additionally sees p_OutReady
  // so a new word can be taken on the final-code handshake without a bubble.
  always_comb begin
    p_OutValid = 1'b0;
    p_Busy     = 1'b0;
    p_Output   = CODE_W'(CODE_NONE);
    p_OutLast  = 1'b0;
    p_InReady  = 1'b0;
    case (r_state)
      IDLE: begin
        p_InReady = 1'b1;
      end
      EMIT: begin
        p_OutValid = 1'b1;
        p_Busy     = 1'b1;
        p_Output   = w_code;
        p_OutLast  = w_one;
        p_InReady  = p_OutReady & w_one;
      end
      default: begin
        p_InReady = 1'b0;
      end
    endcase
  end

  assign w_in_hs  = p_InValid & p_InReady;
  assign w_out_hs = p_OutValid & p_OutReady;

  always_comb begin
    w_state_next = r_state;
    w_pend_next  = r_pend;
    case (r_state)
      IDLE: begin
        if (w_in_hs) begin
          w_pend_next  = p_Input;
          w_state_next = EMIT;
        end
      end
      EMIT: begin
        if (w_out_hs) begin
          if (w_in_hs) begin
            w_pend_next  = p_Input;
            w_state_next = EMIT;
          end else begin
            w_pend_next = r_pend & (r_pend - DATA_W'(1));
            if (p_OutLast) begin
              w_state_next = IDLE;
            end
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_pend_next  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_codificador_sequencial.sv
// Directed self-checking bench: DATA_W=8 instance for the main scenarios and a
// DATA_W=3 instance for the full code sweep.
module tb_codificador_sequencial;

  logic clk;
  logic rst_n;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_last8, busy8;
  logic [7:0] in8;
  logic [3:0] out8;

  logic       in_valid3, in_ready3, out_valid3, out_ready3, out_last3, busy3;
  logic [2:0] in3;
  logic [1:0] out3;

  int errors;
  int checks;

  codificador_sequencial #(.DATA_W(8)) dut8 (
    .p_Clock    (clk),
    .p_Resetn   (rst_n),
    .p_InValid  (in_valid8),
    .p_InReady  (in_ready8),
    .p_Input    (in8),
    .p_OutValid (out_valid8),
    .p_OutReady (out_ready8),
    .p_Output   (out8),
    .p_OutLast  (out_last8),
    .p_Busy     (busy8)
  );

  codificador_sequencial #(.DATA_W(3)) dut3 (
    .p_Clock    (clk),
    .p_Resetn   (rst_n),
    .p_InValid  (in_valid3),
    .p_InReady  (in_ready3),
    .p_Input    (in3),
    .p_OutValid (out_valid3),
    .p_OutReady (out_ready3),
    .p_Output   (out3),
    .p_OutLast  (out_last3),
    .p_Busy     (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid8 = 0; in8 = '0; out_ready8 = 0;
    in_valid3 = 0; in3 = '0; out_ready3 = 0;
    #3;
    checks++;
    if ({out_valid8, out8, out_last8, busy8, in_ready8} !== {1'b0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got v=%b c=%0d l=%b b=%b r=%b, want v=0 c=0 l=0 b=0 r=1",
               out_valid8, out8, out_last8, busy8, in_ready8);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    // Load 8'hF0 with the consumer stalled, then reset mid-emission.
    in_valid8 = 1; in8 = 8'hF0;
    step();
    in_valid8 = 0;
    checks++;
    if ({out_valid8, busy8, out8} !== {1'b1, 1'b1, 4'd5}) begin
      errors++;
      $display("FAIL reset_preload: got v=%b b=%b c=%0d, want v=1 b=1 c=5", out_valid8, busy8, out8);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid8, busy8, in_ready8, out8} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_async: got v=%b b=%b r=%b c=%0d, want v=0 b=0 r=1 c=0",
               out_valid8, busy8, in_ready8, out8);
    end
    step();
    rst_n = 1'b1;
    out_ready8 = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid8 !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_codes[%0d]: got valid=%b, want 0", i, out_valid8);
      end
    end
  endtask

  task automatic test_single_bit();
    out_ready8 = 1; in_valid8 = 1; in8 = 8'b0000_0100;
    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL single_inready: got %b, want 1", in_ready8);
    end
    step();
    in_valid8 = 0;
    checks++;
    if ({out_valid8, out8, out_last8, busy8} !== {1'b1, 4'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL single_code: got v=%b c=%0d l=%b b=%b, want v=1 c=3 l=1 b=1",
               out_valid8, out8, out_last8, busy8);
    end
    step();
    checks++;
    if ({out_valid8, in_ready8, busy8} !== {1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_idle: got v=%b r=%b b=%b, want v=0 r=1 b=0", out_valid8, in_ready8, busy8);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_codes [3];
    exp_codes[0] = 4'd1; exp_codes[1] = 4'd3; exp_codes[2] = 4'd8;
    out_ready8 = 0; in_valid8 = 1; in8 = 8'b1000_0101;
    step();
    in_valid8 = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid8, out8, out_last8, in_ready8} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b c=%0d l=%b r=%b, want v=1 c=1 l=0 r=0",
                 i, out_valid8, out8, out_last8, in_ready8);
      end
      step();
    end
    out_ready8 = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({out_valid8, out8, out_last8} !== {1'b1, exp_codes[i], (i == 2)}) begin
        errors++;
        $display("FAIL stall_seq[%0d]: got v=%b c=%0d l=%b, want v=1 c=%0d l=%b",
                 i, out_valid8, out8, out_last8, exp_codes[i], (i == 2));
      end
      step();
    end
    checks++;
    if (out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: got valid=%b, want 0", out_valid8);
    end
  endtask

  task automatic test_zero();
    out_ready8 = 1; in_valid8 = 1; in8 = 8'h00;
    step();
    in_valid8 = 0;
    checks++;
    if ({out_valid8, out8, out_last8} !== {1'b1, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL zero_code: got v=%b c=%0d l=%b, want v=1 c=0 l=1", out_valid8, out8, out_last8);
    end
    step();
    checks++;
    if ({out_valid8, busy8, in_ready8} !== {1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL zero_idle: got v=%b b=%b r=%b, want v=0 b=0 r=1", out_valid8, busy8, in_ready8);
    end
  endtask

  task automatic test_back_to_back();
    out_ready8 = 1; in_valid8 = 1; in8 = 8'h01;
    step();
    in8 = 8'h80;
    checks++;
    if ({out_valid8, out8, out_last8, in_ready8} !== {1'b1, 4'd1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first: got v=%b c=%0d l=%b r=%b, want v=1 c=1 l=1 r=1",
               out_valid8, out8, out_last8, in_ready8);
    end
    step();
    in_valid8 = 0;
    checks++;
    if ({out_valid8, out8, out_last8, busy8} !== {1'b1, 4'd8, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second: got v=%b c=%0d l=%b b=%b, want v=1 c=8 l=1 b=1",
               out_valid8, out8, out_last8, busy8);
    end
    step();
    checks++;
    if (out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got valid=%b, want 0", out_valid8);
    end
  endtask

  task automatic test_sweep3();
    logic [2:0] words  [5];
    int         counts [5];
    logic [1:0] codes  [7];
    int         idx;
    words[0] = 3'b000; words[1] = 3'b001; words[2] = 3'b010; words[3] = 3'b100; words[4] = 3'b111;
    counts[0] = 1; counts[1] = 1; counts[2] = 1; counts[3] = 1; counts[4] = 3;
    codes[0] = 2'd0; codes[1] = 2'd1; codes[2] = 2'd2; codes[3] = 2'd3;
    codes[4] = 2'd1; codes[5] = 2'd2; codes[6] = 2'd3;
    idx = 0;
    out_ready3 = 1;
    for (int w = 0; w < 5; w++) begin
      in_valid3 = 1; in3 = words[w];
      step();
      in_valid3 = 0;
      for (int k = 0; k < counts[w]; k++) begin
        checks++;
        if ({out_valid3, out3, out_last3} !== {1'b1, codes[idx], (k == counts[w] - 1)}) begin
          errors++;
          $display("FAIL sweep3[w=%0d k=%0d]: got v=%b c=%0d l=%b, want v=1 c=%0d l=%b",
                   w, k, out_valid3, out3, out_last3, codes[idx], (k == counts[w] - 1));
        end
        idx++;
        step();
      end
      checks++;
      if (out_valid3 !== 1'b0) begin
        errors++;
        $display("FAIL sweep3_idle[w=%0d]: got valid=%b, want 0", w, out_valid3);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_bit();
    test_backpressure();
    test_zero();
    test_back_to_back();
    test_sweep3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
